// File: rtl/byte_serial_add_ctrl_if.sv
// Handshake bundle for byte_serial_add_ctrl: an operand request channel and a result channel,
// each with valid/ready. The producer/consumer side uses master; the sequencer uses slave.
interface byte_serial_add_ctrl_if #(
  parameter int WORDS = 4
);
  localparam int W = 8 * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         sub;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial WORDS x 8-bit add/subtract: one carry-select byte adder is reused LSB-first,
// with the inter-slice carry held in a register. Result held under valid/ready backpressure.

// 8-bit carry-select adder: the low nibble ripples, the high nibble is computed for both
// possible carries and the low nibble's carry picks the right one.
module select_adder8 (
  output logic [7:0] s,
  output logic       co,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  always_comb begin
    lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
    hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    hi1 = {1'b0, a[7:4]} + {1'b0, b[7:4]} + 5'd1;
  end

  assign s[3:0] = lo[3:0];
  assign s[7:4] = lo[4] ? hi1[3:0] : hi0[3:0];
  assign co     = lo[4] ? hi1[4]   : hi0[4];
endmodule

module byte_serial_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  byte_serial_add_ctrl_if.slave bus
);
  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;

  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic             a_msb;
  logic             beff_msb;

  logic [W-1:0]     sum_q;
  logic             co_q;
  logic             ovf_q;

  logic [7:0]       slice_s;
  logic             slice_co;

  logic             accept;
  logic             step;
  logic             last;

  select_adder8 u_adder (
    .s  (slice_s),
    .co (slice_co),
    .a  (a_sh[7:0]),
    .b  (b_sh[7:0]),
    .ci (carry_q)
  );

  // in_ready is gated by rst so an upstream producer never sees a handshake during reset.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign step   = (state_q == RUN);
  assign last   = step && (idx_q == LAST_IDX);

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q   <= '0;
        carry_q <= bus.sub ? 1'b1 : bus.ci;
      end else if (step) begin
        idx_q   <= idx_q + 1'b1;
        carry_q <= slice_co;
        sum_q   <= {slice_s, sum_q[W-1:8]};
        if (last) begin
          co_q  <= slice_co;
          ovf_q <= (a_msb == beff_msb) && (slice_s[7] != a_msb);
        end
      end
    end
  end

  // NOTE: the operand shift registers are pure datapath, always loaded before use, so they
  // carry no reset; keeping them out of the reset block also avoids a reset-as-enable mux.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh     <= bus.a;
      b_sh     <= bus.sub ? ~bus.b : bus.b;
      a_msb    <= bus.a[W-1];
      beff_msb <= bus.sub ? ~bus.b[W-1] : bus.b[W-1];
    end else if (step) begin
      a_sh <= {8'h00, a_sh[W-1:8]};
      b_sh <= {8'h00, b_sh[W-1:8]};
    end
  end
endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Self-checking bench for byte_serial_add_ctrl (WORDS=4): directed vector table, backpressure
// and mid-run reset sequences, then random operations against an arithmetic reference model.
module tb_byte_serial_add_ctrl;
  localparam int WORDS = 4;
  localparam int W     = 8 * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  byte_serial_add_ctrl_if #(.WORDS(WORDS)) bus ();

  byte_serial_add_ctrl #(.WORDS(WORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_co;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic: unsigned result for sum/carry, signed
  // range check for overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                input logic sub, output logic [W-1:0] s, output logic c,
                                output logic o);
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint full;
    longint sres;
    if (sub) begin
      full = ua - ub;
      c    = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + longint'(ci);
      c    = (full >= 64'sh1_0000_0000);
      sres = sa + sb + longint'(ci);
    end
    s = full[W-1:0];
    o = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
  endfunction

  // One full transaction. stall = cycles to hold out_ready low in DONE while a competing
  // in_valid is presented; stability and non-acceptance are checked each of those cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sub, input int stall, output logic [W-1:0] s,
                        output logic c, output logic o);
    int n;
    int lat;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.ci = ci; bus.sub = sub; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.ci = 1'($urandom); bus.sub = 1'($urandom);
    check("in_ready_in_run", bus.in_ready, 0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, WORDS);
    s = bus.sum; c = bus.co; o = bus.ovf;
    if (stall > 0) begin
      bus.in_valid = 1'b1;
      bus.a = 32'h1111_1111; bus.b = 32'h2222_2222;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("stall_valid", bus.out_valid, 1);
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_sum", bus.sum, s);
        check("stall_flags", {bus.co, bus.ovf}, {c, o});
      end
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_idle", bus.in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic [W-1:0] ms;
    logic         mc;
    logic         mo;

    vecs.push_back('{"add_5_10",     32'd5,          32'd10,         1'b1, 1'b0, 32'd16,         1'b0, 1'b0});
    vecs.push_back('{"full_ripple",  32'hFFFF_FFFF,  32'h0000_0000,  1'b1, 1'b0, 32'h0000_0000,  1'b1, 1'b0});
    vecs.push_back('{"ovf_pos",      32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 32'h8000_0000,  1'b0, 1'b1});
    vecs.push_back('{"ovf_neg",      32'h8000_0000,  32'h8000_0000,  1'b0, 1'b0, 32'h0000_0000,  1'b1, 1'b1});
    vecs.push_back('{"sub_borrow",   32'd10,         32'd33,         1'b1, 1'b1, 32'hFFFF_FFE9,  1'b0, 1'b0});
    vecs.push_back('{"sub_noborrow", 32'd33,         32'd10,         1'b0, 1'b1, 32'd23,         1'b1, 1'b0});
    vecs.push_back('{"sub_ovf",      32'h8000_0000,  32'd1,          1'b0, 1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1});

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.ci = 1'b0; bus.sub = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_flags", {bus.co, bus.ovf}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // Directed table
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, 0, s, c, o);
      check({vecs[i].name, "_sum"}, s, vecs[i].exp_sum);
      check({vecs[i].name, "_co"}, c, vecs[i].exp_co);
      check({vecs[i].name, "_ovf"}, o, vecs[i].exp_ovf);
    end

    // Backpressure: 5 stalled DONE cycles with a competing request, then a clean op after
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 5, s, c, o);
    check("bp_sum", s, 32'h8000_0000);
    check("bp_flags", {c, o}, 2'b01);
    run_op(32'd100, 32'd200, 1'b0, 1'b0, 0, s, c, o);
    check("after_bp_sum", s, 32'd300);

    // Reset mid-RUN after slice 2
    @(negedge clk);
    bus.a = 32'h0102_0304; bus.b = 32'h1020_3040; bus.ci = 1'b0; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_run_partial_nonzero", bus.sum != 0, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_sum", bus.sum, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_release_idle", bus.in_ready, 1);
    run_op(32'd5, 32'd10, 1'b0, 1'b0, 0, s, c, o);
    check("after_rst_sum", s, 32'd15);
    check("after_rst_flags", {c, o}, 2'b00);

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rci;
      logic         rsub;
      ra = $urandom; rb = $urandom; rci = 1'($urandom); rsub = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      if (i % 8 == 1) ra = {1'b0, 31'($urandom)} | 32'h4000_0000;
      model(ra, rb, rci, rsub, ms, mc, mo);
      run_op(ra, rb, rci, rsub, (i % 10 == 3) ? 2 : 0, s, c, o);
      check("rand_sum", s, ms);
      check("rand_co", c, mc);
      check("rand_ovf", o, mo);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/byte_serial_add_ctrl.md
# byte_serial_add_ctrl

Sequencer that performs WORDS×8-bit add/subtract operations by time-multiplexing one `select_adder8` carry-select adder over successive byte slices, least-significant byte first, with the carry registered between slices. It sits between an operand producer and a result consumer, each using a valid/ready handshake. It is the only driver of its `select_adder8` instance.

## Interface
- `WORDS`, default 4: number of byte slices; operand width is 8*WORDS. Legal range is 2..16.
- `clk`  in  1  rising-edge clock for all state.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands and mode are presented.
- `in_ready`  out  1  block can accept operands. High only in IDLE, and forced 0 while `rst` is high.
- `a`, `b`  in  8*WORDS  operands, sampled on acceptance.
- `ci`  in  1  carry-in for add; ignored when `sub`=1.
- `sub`  in  1  1 selects a−b, computed as a + ~b + 1.
- `out_valid`  out  1  result is held stable.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  8*WORDS  registered result.
- `co`  out  1  final carry-out. For subtraction, 1 means no borrow.
- `ovf`  out  1  signed two's-complement overflow of the full-width operation.

## Operation
- Instantiates `select_adder8(s, co, a, b, ci)` once. Its inputs come from the low byte of the operand shift registers and from `carry_q`.
- States: IDLE, RUN, DONE.
  - IDLE → RUN on accept (`in_valid && in_ready`).
  - RUN → DONE when `idx == WORDS-1`, after that slice is stored.
  - DONE → IDLE on `out_valid && out_ready`.
- On accept:
  - `a_sh <= a`.
  - `b_sh <= sub ? ~b : b`.
  - `carry_q <= sub ? 1 : ci`.
  - `idx <= 0`.
  - Latch the MSB of `a` and the MSB of the effective b for the overflow check.
- Each RUN cycle:
  - Adder computes `a_sh[7:0] + b_sh[7:0] + carry_q`.
  - `sum` shifts right 8 bits, and the adder's `s` enters at bits [8*WORDS-1 : 8*WORDS-8].
  - `a_sh` and `b_sh` shift right 8 bits.
  - `carry_q <= adder co`.
  - `idx` increments.
- On the last slice:
  - `co <= adder co`.
  - `ovf <= (a_msb == beff_msb) && (s[7] != a_msb)`.
- `sum`, `co` and `ovf` are held unchanged from entry to DONE until the next accept. Outside DONE they are don't-care for consumers but must not glitch while `out_valid` is high.
- All arithmetic is modulo 2^(8*WORDS). No saturation.

## Timing
- Reset values:
  - State IDLE, `idx`=0, `carry_q`=0.
  - `sum`=0, `co`=0, `ovf`=0.
  - `out_valid`=0, `in_ready`=0 while `rst` is high, then 1.
- Latency: if accepted at edge k, slices are computed at edges k+1 … k+WORDS. `out_valid` rises after edge k+WORDS, so latency is WORDS cycles.
- Throughput: one operation per WORDS+2 cycles at best. There is one IDLE cycle after DONE, because `in_ready` is 0 in RUN and DONE.
- Backpressure: DONE persists indefinitely while `out_ready`=0. `sum`, `co` and `ovf` stay stable.
- `in_valid` while not ready is ignored. Operands do not need to be held after acceptance.
- `out_ready` high outside DONE has no effect.
- Asynchronous `rst` in any state aborts the operation immediately. No partial result is presented. After release, the next operation starts cleanly from IDLE.
- The adder is combinational within one cycle. Its path from `carry_q` and the low bytes to the `sum`/`carry_q` registers must meet a single clock period.

## Test plan
- WORDS=4, add: a=5, b=10, ci=1 → after 4 cycles `out_valid`=1, `sum`=16, `co`=0, `ovf`=0.
- Add with full ripple: a=0xFFFFFFFF, b=0x00000000, ci=1 → `sum`=0x00000000, `co`=1, `ovf`=0. This checks carry propagation through all four slices.
- Signed overflow: a=0x7FFFFFFF, b=1, ci=0 → `sum`=0x80000000, `co`=0, `ovf`=1. Also a=0x80000000, b=0x80000000, ci=0 → `sum`=0, `co`=1, `ovf`=1.
- Subtract: a=10, b=33, `sub`=1, ci=1 → `sum`=0xFFFFFFE9, `co`=0 (borrow), `ovf`=0. Also a=33, b=10, `sub`=1 → `sum`=23, `co`=1. This confirms `ci` is ignored when `sub`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `sum`, `co`, `ovf` and `out_valid` are stable, `in_ready`=0, and a new `in_valid` is not accepted. Then `out_ready`=1 → IDLE, and `in_ready`=1 on the next cycle.
- Reset mid-RUN: assert `rst` after slice 2 of a=0x01020304 + b=0x10203040 → `out_valid`=0 and `sum`=0 immediately. After release, a fresh 5+10 (ci=0) returns `sum`=15 after 4 cycles.
